serial_adder_ctrl: RTL

Bit-serial add controller that reuses a single 1-bit full-adder cell across WIDTH clock cycles to produce a WIDTH-bit sum, trading latency for area against the parallel ripple-carry adders in the combinational library. It captures operands on a start strobe, sequences the full adder LSB-first with a registered carry, and reports completion with a one-cycle done pulse. It sits between a requesting controller and any consumer of sum/carry/overflow that can tolerate multi-cycle latency.

---
 rtl/serial_adder_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder reusing one full-adder cell over WIDTH cycles.
// Define SERIAL_SUB_EN to make sub=1 compute a - b; otherwise sub is ignored.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q, cout_q, ovf_q;
  logic             sub_en, bit_d, carry_d, last_d;
  logic [WIDTH-1:0] b_load_d, acc_d;
`ifdef SERIAL_SUB_EN
  assign sub_en = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_en = 1'b0;
`endif
  always_comb begin
    b_load_d = sub_en ? ~b : b;
    bit_d    = a_q[0] ^ b_q[0] ^ carry_q;
    carry_d  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    acc_d    = {bit_d, acc_q[WIDTH-1:1]};
    last_d   = cnt_q == CW'(WIDTH - 1);
  end
  // DONE also samples start, so a back-to-back request is accepted at edge WIDTH+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          acc_q   <= acc_d;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last_d) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= acc_d;
            cout_q  <= carry_d;
            ovf_q   <= carry_q ^ carry_d;
          end
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= start;
          state_q <= start ? RUN : IDLE;
          if (start) begin
            a_q     <= a;
            b_q     <= b_load_d;
            carry_q <= sub_en | cin;
            cnt_q   <= '0;
            acc_q   <= '0;
          end
        end
      endcase
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
endmodule
